pair_serializer: RTL

- Captures a frame of 2*NUM_PAIRS W-bit samples in one transfer, then emits it one sample pair per beat: elements 0/1 first, then 2/3, and so on.
- Uses valid/ready handshakes on both sides.
- Sits in iq_demod between the sample-window buffer and the downstream pair-wise correlator.
- Adds parametrised width and pair count, internal index sequencing, backpressure and back-to-back frames over a fixed 10-input pair mux.

---
 rtl/iq_demod_pkg.sv | 23 ++
 rtl/pair_serializer_pair_select.sv | 32 +++
 rtl/pair_serializer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/iq_demod_pkg.sv
// Shared types and helpers for the iq_demod datapath.
//   SAMPLE_W    : default sample width
//   sample_t    : one sample
//   ser_state_t : pair_serializer FSM states
//   sel_width() : width of a pair index, never below 1
package iq_demod_pkg;

   localparam int unsigned SAMPLE_W = 9;

   typedef logic [SAMPLE_W-1:0] sample_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_t;

   function automatic int unsigned sel_width(input int unsigned n);
      int unsigned r;
      r = (n <= 1) ? 1 : $clog2(n);
      return r;
   endfunction

endpackage

// File: rtl/pair_serializer_pair_select.sv
// Combinational pair mux: picks elements 2k and 2k+1 of a flattened frame.
//   frame_i : 2*NUM_PAIRS*W flattened frame, element e at [e*W +: W]
//   idx_i   : pair index k
//   even_o  : element 2k   (0 when k is out of range)
//   odd_o   : element 2k+1 (0 when k is out of range)
module pair_select
   import iq_demod_pkg::*;
#(
   parameter  int unsigned W         = SAMPLE_W,
   parameter  int unsigned NUM_PAIRS = 5,
   localparam int unsigned SEL_W     = sel_width(NUM_PAIRS),
   localparam int unsigned FRAME_W   = 2 * NUM_PAIRS * W
) (
   input  logic [FRAME_W-1:0] frame_i,
   input  logic [SEL_W-1:0]   idx_i,
   output logic [W-1:0]       even_o,
   output logic [W-1:0]       odd_o
);

   // One-hot style compare per pair; unmatched index leaves the zero default.
   always_comb begin
      even_o = '0;
      odd_o  = '0;
      for (int k = 0; k < int'(NUM_PAIRS); k++) begin
         if (idx_i == SEL_W'(k)) begin
            even_o = frame_i[(2*k)*W   +: W];
            odd_o  = frame_i[(2*k+1)*W +: W];
         end
      end
   end

endmodule

// File: rtl/pair_serializer.sv
// Frame-to-pair serializer: accepts 2*NUM_PAIRS samples in one transfer and
// emits them one (even, odd) pair per beat with valid/ready on both sides.
// Optional feature macro: PAIR_SER_LAST_EN adds out_last (final pair marker).
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : flattened frame, element e at [e*W +: W]
//   in_valid   : frame available
//   in_ready   : frame accepted this cycle when in_valid=1
//   out1/out2  : even/odd element of the current pair (0 when not valid)
//   out_sel    : current pair index
//   out_valid  : pair valid
//   out_ready  : downstream accepts the pair
//   busy       : a frame is held
//   out_last   : (PAIR_SER_LAST_EN only) current pair is the final one
module pair_serializer
   import iq_demod_pkg::*;
#(
   parameter  int unsigned W         = SAMPLE_W,
   parameter  int unsigned NUM_PAIRS = 5,
   localparam int unsigned SEL_W     = sel_width(NUM_PAIRS),
   localparam int unsigned FRAME_W   = 2 * NUM_PAIRS * W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [FRAME_W-1:0] in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [W-1:0]       out1,
   output logic [W-1:0]       out2,
   output logic [SEL_W-1:0]   out_sel,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               busy
`ifdef PAIR_SER_LAST_EN
   ,
   output logic               out_last
`endif
);

   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_PAIRS - 1);

   ser_state_t         state_q, state_d;
   logic [SEL_W-1:0]   idx_q, idx_d;
   logic [FRAME_W-1:0] buf_q;
   logic               is_last;
   logic               beat;
   logic               accept;
   logic [W-1:0]       even;
   logic [W-1:0]       odd;

   assign is_last = (idx_q == LAST_IDX);
   assign beat    = (state_q == SEND) && out_ready;
   assign accept  = in_valid && in_ready;

   // State and index registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Frame buffer; contents are meaningless outside SEND so no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         buf_q <= in_data;
      end
   end

   // Next state: a completing final beat may chain straight into a new frame.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = SEND;
               idx_d   = '0;
            end
         end
         SEND: begin
            if (beat) begin
               if (!is_last) begin
                  idx_d = idx_q + SEL_W'(1);
               end else if (in_valid) begin
                  idx_d = '0;
               end else begin
                  state_d = IDLE;
                  idx_d   = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   pair_select #(
      .W         (W),
      .NUM_PAIRS (NUM_PAIRS)
   ) u_pair_select (
      .frame_i (buf_q),
      .idx_i   (idx_q),
      .even_o  (even),
      .odd_o   (odd)
   );

   // Outputs: derived only from state, index and buffer, except in_ready which
   // follows out_ready on the final beat to allow gapless frames.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      out_sel   = idx_q;
      out1      = '0;
      out2      = '0;
`ifdef PAIR_SER_LAST_EN
      out_last  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
         end
         SEND: begin
            in_ready  = out_ready && is_last;
            out_valid = 1'b1;
            busy      = 1'b1;
            out1      = even;
            out2      = odd;
`ifdef PAIR_SER_LAST_EN
            out_last  = is_last;
`endif
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

endmodule
